// File: rtl/axi_arbiter_w_rr.sv
// Round-robin AXI4 write-channel arbiter: one master owns the slave path from AW through WLAST to B.
// Define AXI_ARB_W_TIMEOUT_EN to add a watchdog that aborts a stalled transaction.
module axi_arbiter_w_rr #(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned IDX_W          = $clog2(NUM_MASTERS),
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [NUM_MASTERS-1:0] m_AWVALID,
    input  logic [NUM_MASTERS-1:0] m_WVALID,
    input  logic [NUM_MASTERS-1:0] m_WLAST,
    input  logic [NUM_MASTERS-1:0] m_BREADY,
    input  logic                   s_AWREADY,
    input  logic                   s_WREADY,
    input  logic                   s_BVALID,
    output logic [NUM_MASTERS-1:0] wgrnt,
    output logic [IDX_W-1:0]       grnt_idx,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int unsigned CAND_W = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_RESP
    } state_e;

    state_e                 state_q;
    logic [NUM_MASTERS-1:0] wgrnt_q;
    logic [IDX_W-1:0]       grnt_idx_q;
    logic [IDX_W-1:0]       last_owner_q;
    logic                   busy_q;
    logic                   timeout_err_q;
    logic                   aw_done_q;
    logic                   w_done_q;

    logic                   win_vld_d;
    logic [IDX_W-1:0]       win_idx_d;
    logic [CAND_W-1:0]      cand;

    logic                   aw_hs;
    logic                   w_hs;
    logic                   wlast_hs;
    logic                   b_hs;
    logic                   xfer_done;
    logic                   tmo_hit;

    // Scan from last_owner+1 upward with wrap; the first requester found wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path infers a latch.
        win_vld_d = 1'b0;
        win_idx_d = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            cand = {1'b0, last_owner_q} + CAND_W'(k);
            if (cand >= CAND_W'(NUM_MASTERS)) begin
                cand = cand - CAND_W'(NUM_MASTERS);
            end
            if (!win_vld_d && m_AWVALID[cand[IDX_W-1:0]]) begin
                win_vld_d = 1'b1;
                win_idx_d = cand[IDX_W-1:0];
            end
        end
    end

    assign aw_hs     = m_AWVALID[grnt_idx_q] & s_AWREADY;
    assign w_hs      = m_WVALID[grnt_idx_q] & s_WREADY;
    assign wlast_hs  = w_hs & m_WLAST[grnt_idx_q];
    assign b_hs      = s_BVALID & m_BREADY[grnt_idx_q];
    assign xfer_done = (aw_done_q | aw_hs) & (w_done_q | wlast_hs);

`ifdef AXI_ARB_W_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMR_W-1:0] tmr_q;

    // Any owner handshake proves liveness; the count only advances while a transaction is owned.
    assign tmo_hit = (state_q != ST_IDLE) && !(aw_hs || w_hs || b_hs) &&
                     (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            tmr_q <= '0;
        end else if (state_q == ST_IDLE || aw_hs || w_hs || b_hs || tmo_hit) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_q + TMR_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo_hit            = 1'b0;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q       <= ST_IDLE;
            wgrnt_q       <= '0;
            grnt_idx_q    <= '0;
            last_owner_q  <= IDX_W'(NUM_MASTERS - 1);
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_vld_d) begin
                        state_q    <= ST_XFER;
                        wgrnt_q    <= NUM_MASTERS'(1) << win_idx_d;
                        grnt_idx_q <= win_idx_d;
                        busy_q     <= 1'b1;
                    end
                end
                ST_XFER, ST_RESP: begin
                    if (tmo_hit || (state_q == ST_RESP && b_hs)) begin
                        // Completion and watchdog abort both hand priority past the owner.
                        state_q       <= ST_IDLE;
                        wgrnt_q       <= '0;
                        busy_q        <= 1'b0;
                        last_owner_q  <= grnt_idx_q;
                        aw_done_q     <= 1'b0;
                        w_done_q      <= 1'b0;
                        timeout_err_q <= tmo_hit;
                    end else if (state_q == ST_XFER) begin
                        if (aw_hs) begin
                            aw_done_q <= 1'b1;
                        end
                        if (wlast_hs) begin
                            w_done_q <= 1'b1;
                        end
                        if (xfer_done) begin
                            state_q <= ST_RESP;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    wgrnt_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wgrnt       = wgrnt_q;
    assign grnt_idx    = grnt_idx_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_axi_arbiter_w_rr.sv
// Self-checking bench for axi_arbiter_w_rr: transaction-level reference model plus directed scenarios.
// Timeout expectations switch on AXI_ARB_W_TIMEOUT_EN (watchdog limit 16 here).
module tb_axi_arbiter_w_rr;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 16;

`ifdef AXI_ARB_W_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [N-1:0]  m_AWVALID;
    logic [N-1:0]  m_WVALID;
    logic [N-1:0]  m_WLAST;
    logic [N-1:0]  m_BREADY;
    logic          s_AWREADY;
    logic          s_WREADY;
    logic          s_BVALID;
    logic [N-1:0]  wgrnt;
    logic [IW-1:0] grnt_idx;
    logic          busy;
    logic          timeout_err;

    int vectors;
    int miscompares;

    always #5 ACLK = ~ACLK;

    axi_arbiter_w_rr #(
        .NUM_MASTERS   (N),
        .IDX_W         (IW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .m_AWVALID  (m_AWVALID),
        .m_WVALID   (m_WVALID),
        .m_WLAST    (m_WLAST),
        .m_BREADY   (m_BREADY),
        .s_AWREADY  (s_AWREADY),
        .s_WREADY   (s_WREADY),
        .s_BVALID   (s_BVALID),
        .wgrnt      (wgrnt),
        .grnt_idx   (grnt_idx),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the path, which halves of the write are done, who went last.
    int m_owner;
    int m_last;
    int m_idx;
    bit m_aw;
    bit m_w;
    bit m_err;
`ifdef AXI_ARB_W_TIMEOUT_EN
    int m_quiet;
`endif
    int g;
    int c;
    bit awh;
    bit wh;
    bit wl;
    bit bh;
    bit found;

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            m_owner = -1;
            m_last  = N - 1;
            m_idx   = 0;
            m_aw    = 1'b0;
            m_w     = 1'b0;
            m_err   = 1'b0;
`ifdef AXI_ARB_W_TIMEOUT_EN
            m_quiet = 0;
`endif
        end else begin
            m_err = 1'b0;
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (!found && m_AWVALID[c]) begin
                        found   = 1'b1;
                        m_owner = c;
                        m_idx   = c;
                    end
                end
`ifdef AXI_ARB_W_TIMEOUT_EN
                m_quiet = 0;
`endif
            end else begin
                g   = m_owner;
                awh = m_AWVALID[g] && s_AWREADY;
                wh  = m_WVALID[g] && s_WREADY;
                wl  = wh && m_WLAST[g];
                bh  = s_BVALID && m_BREADY[g];
                found = 1'b0;
`ifdef AXI_ARB_W_TIMEOUT_EN
                if (!(awh || wh || bh) && (m_quiet + 1 >= TO)) begin
                    found   = 1'b1;
                    m_err   = 1'b1;
                    m_last  = g;
                    m_owner = -1;
                    m_aw    = 1'b0;
                    m_w     = 1'b0;
                end
                m_quiet = (awh || wh || bh) ? 0 : m_quiet + 1;
`endif
                if (!found) begin
                    if (m_aw && m_w) begin
                        if (bh) begin
                            m_last  = g;
                            m_owner = -1;
                            m_aw    = 1'b0;
                            m_w     = 1'b0;
                        end
                    end else begin
                        m_aw = m_aw || awh;
                        m_w  = m_w || wl;
                    end
                end
            end
        end
    end

    logic [31:0] exp_grant;

    always @(negedge ACLK) begin
        exp_grant = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
        check("model_wgrnt", 32'(wgrnt), exp_grant);
        check("model_grnt_idx", 32'(grnt_idx), 32'(m_idx));
        check("model_busy", 32'(busy), 32'(m_owner >= 0));
        check("model_timeout_err", 32'(timeout_err), 32'(m_err));
        check("onehot", 32'($countones(wgrnt) > 1), 32'd0);
    end

    task automatic tick();
        @(negedge ACLK);
    endtask

    task automatic clr();
        m_AWVALID = '0;
        m_WVALID  = '0;
        m_WLAST   = '0;
        m_BREADY  = '0;
        s_AWREADY = 1'b0;
        s_WREADY  = 1'b0;
        s_BVALID  = 1'b0;
    endtask

    logic [N-1:0] rr_exp [5];
    logic [N-1:0] w1_exp [6];

    initial begin
        vectors     = 0;
        miscompares = 0;
        rr_exp      = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        w1_exp      = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
        ARESET      = 1'b1;
        clr();
        tick();
        tick();
        check("rst_wgrnt", 32'(wgrnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grnt_idx", 32'(grnt_idx), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);

        // Everyone requests with all handshakes ready: a new grant every 3 cycles, rotating.
        ARESET    = 1'b0;
        m_AWVALID = '1;
        m_WVALID  = '1;
        m_WLAST   = '1;
        m_BREADY  = '1;
        s_AWREADY = 1'b1;
        s_WREADY  = 1'b1;
        s_BVALID  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_sequence", 32'(wgrnt), 32'(rr_exp[k]));
            tick();
            tick();
        end
        clr();

        // Master 2 alone: AW at 3, WLAST at 8, B at 12.
        for (int cy = 0; cy <= 14; cy++) begin
            check("m2_window", 32'(wgrnt), (cy >= 1 && cy <= 12) ? 32'h4 : 32'h0);
            m_AWVALID = (cy <= 3) ? 4'b0100 : 4'b0000;
            s_AWREADY = (cy == 3);
            m_WVALID  = (cy >= 5 && cy <= 8) ? 4'b0100 : 4'b0000;
            s_WREADY  = 1'b1;
            m_WLAST   = (cy == 8) ? 4'b0100 : 4'b0000;
            m_BREADY  = (cy >= 10 && cy <= 12) ? 4'b0100 : 4'b0000;
            s_BVALID  = (cy == 12);
            tick();
        end

        // Master 1: single-beat burst with AW in the same cycle; master 3 waits; B stalled 5 cycles.
        clr();
        m_AWVALID = 4'b0010;
        tick();
        check("m1_grant", 32'(wgrnt), 32'h2);
        m_AWVALID = 4'b1010;
        s_AWREADY = 1'b1;
        m_WVALID  = 4'b0010;
        m_WLAST   = 4'b0010;
        s_WREADY  = 1'b1;
        tick();
        m_AWVALID = 4'b1000;
        s_AWREADY = 1'b0;
        m_WVALID  = '0;
        m_WLAST   = '0;
        s_BVALID  = 1'b1;
        m_BREADY  = '0;
        for (int k = 0; k < 5; k++) begin
            check("b_hold", 32'(wgrnt), 32'h2);
            tick();
        end
        check("b_hold_last", 32'(wgrnt), 32'h2);
        m_BREADY = 4'b0010;
        tick();
        check("b_release_wgrnt", 32'(wgrnt), 32'h0);
        check("b_release_busy", 32'(busy), 32'd0);
        s_BVALID = 1'b0;
        m_BREADY = '0;
        tick();
        check("m3_grant", 32'(wgrnt), 32'h8);
        check("m3_idx", 32'(grnt_idx), 32'd3);

        // Asynchronous reset in the middle of master 3's transaction.
        m_AWVALID = '1;
        tick();
        check("pre_rst_m3", 32'(wgrnt), 32'h8);
        #2 ARESET = 1'b1;
        #1;
        check("async_rst_wgrnt", 32'(wgrnt), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_idx", 32'(grnt_idx), 32'd0);
        tick();
        ARESET = 1'b0;
        tick();
        check("post_rst_grant", 32'(wgrnt), 32'h1);

        // Master 0: WLAST before AW, then re-granted after B with only itself requesting.
        for (int d = 0; d < 6; d++) begin
            check("w_before_aw", 32'(wgrnt), 32'(w1_exp[d]));
            clr();
            m_AWVALID = (d == 5) ? 4'b0011 : 4'b0001;
            s_WREADY  = 1'b1;
            m_WVALID  = (d == 0) ? 4'b0001 : 4'b0000;
            m_WLAST   = (d == 0) ? 4'b0001 : 4'b0000;
            s_AWREADY = (d == 2);
            s_BVALID  = (d == 3);
            m_BREADY  = (d == 3) ? 4'b0001 : 4'b0000;
            tick();
        end

        // Owner 0 stalls with no handshake; only the watchdog build may abort.
        for (int s = 1; s <= 17; s++) begin
            if (s == 16) begin
                check("stall_timeout_err", 32'(timeout_err), TMO_EN ? 32'd1 : 32'd0);
                check("stall_wgrnt", 32'(wgrnt), TMO_EN ? 32'h0 : 32'h1);
            end
            if (s == 17) begin
                check("stall_next_grant", 32'(wgrnt), TMO_EN ? 32'h2 : 32'h1);
                check("stall_err_pulse", 32'(timeout_err), 32'd0);
            end
            if (s < 17) begin
                tick();
            end
        end

        clr();
        tick();
        tick();
        @(posedge ACLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
